mem_port_arbiter: RTL and testbench

Shares one single-ported, registered-output 32-bit RAM between the fetch stage (instruction reads) and the memory-access stage (data loads/stores/pop) of the LALU pipeline. Decides each cycle which requester drives the RAM port, returns read data to the right stage one cycle later, and reports grants so the pipeline can stall the loser. Sits between the pipeline and the RAM, in place of a dual-ported memory.

---
 rtl/lalu_mem_pkg.sv | 26 ++
 rtl/mem_port_arbiter_starve_counter.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lalu_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lalu_mem_pkg                                                               |
// | Shared widths, owner encoding and helpers for the LALU memory port arbiter.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lalu_mem_pkg;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  // Which requester is owed the RAM's read data on the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_MEM   = 2'd2
  } owner_t;

  // A zero limit still needs a one-bit counter to compare against.
  function automatic int starve_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage : lalu_mem_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_starve_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | starve_counter                                                             |
// | Counts memory-stage wins while fetch waits; forces one fetch grant at limit|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module starve_counter
  import lalu_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = lalu_mem_pkg::STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fetch_req,
  input  logic fetch_gnt,
  input  logic mem_gnt,
  output logic force_fetch
);

  localparam int             CNT_W = starve_cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_d;
  logic [CNT_W-1:0] starve_cnt_q;

  // Only losses suffered while fetch is still asking count towards the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!fetch_req || fetch_gnt) begin
      starve_cnt_d = '0;
    end else if (mem_gnt && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign force_fetch = fetch_req && (starve_cnt_q == LIMIT);

endmodule : starve_counter
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter                                                           |
// | Shares one registered-output RAM port between fetch and the memory stage.  |
// | Optional fetch starvation guard: define LALU_STARVE_GUARD_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
  import lalu_mem_pkg::*;
#(
  parameter int ADDR_W       = lalu_mem_pkg::ADDR_W,
  parameter int DATA_W       = lalu_mem_pkg::DATA_W,
  parameter int STARVE_LIMIT = lalu_mem_pkg::STARVE_LIMIT
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic              fetchGnt,
  output logic              fetchValid,
  output logic [DATA_W-1:0] fetchData,
  input  logic              memReq,
  input  logic              memWren,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] memWdata,
  output logic              memGnt,
  output logic              memValid,
  output logic [DATA_W-1:0] memRdata,
  output logic [ADDR_W-1:0] ramAddr,
  output logic              ramWren,
  output logic [DATA_W-1:0] ramWdata,
  input  logic [DATA_W-1:0] ramRdata
);

  if (STARVE_LIMIT < 0) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be non-negative");
  end

  logic   force_fetch;
  owner_t owner_d;
  owner_t owner_q;
  logic   fetch_valid_d;
  logic   fetch_valid_q;
  logic   mem_valid_d;
  logic   mem_valid_q;

`ifdef LALU_STARVE_GUARD_EN
  starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .clk         (CLOCK_50),
    .rst_n       (RESET_N),
    .fetch_req   (fetchReq),
    .fetch_gnt   (fetchGnt),
    .mem_gnt     (memGnt),
    .force_fetch (force_fetch)
  );
`else
  assign force_fetch = 1'b0;
`endif

  // The older instruction in the memory stage wins unless fetch has starved.
  assign memGnt   = memReq && !force_fetch;
  assign fetchGnt = fetchReq && !memGnt;

  always_comb begin
    ramAddr = '0;
    if (memGnt) begin
      ramAddr = memAddr;
    end else if (fetchGnt) begin
      ramAddr = fetchAddr;
    end
  end

  // A write strobe must never reach the RAM while the pipeline is in reset.
  assign ramWren  = memGnt && memWren && RESET_N;
  assign ramWdata = memWdata;

  // Writes return nothing, so they leave the port unowned for the next cycle.
  always_comb begin
    owner_d = OWN_NONE;
    if (memGnt && !memWren) begin
      owner_d = OWN_MEM;
    end else if (fetchGnt) begin
      owner_d = OWN_FETCH;
    end
    fetch_valid_d = (owner_d == OWN_FETCH);
    mem_valid_d   = (owner_d == OWN_MEM);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      owner_q       <= OWN_NONE;
      fetch_valid_q <= 1'b0;
      mem_valid_q   <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      fetch_valid_q <= fetch_valid_d;
      mem_valid_q   <= mem_valid_d;
    end
  end

  assign fetchValid = fetch_valid_q;
  assign memValid   = mem_valid_q;
  assign fetchData  = (owner_q == OWN_FETCH) ? ramRdata : '0;
  assign memRdata   = (owner_q == OWN_MEM)   ? ramRdata : '0;

  a_one_grant : assert property (@(posedge CLOCK_50) disable iff (!RESET_N)
    !(fetchGnt && memGnt));

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                        |
// | Directed plus randomized bench against a transaction-level reference.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int MEM_WORDS    = 1 << ADDR_W;
`ifdef LALU_STARVE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  logic              CLOCK_50;
  logic              RESET_N;
  logic              fetchReq;
  logic [ADDR_W-1:0] fetchAddr;
  logic              fetchGnt;
  logic              fetchValid;
  logic [DATA_W-1:0] fetchData;
  logic              memReq;
  logic              memWren;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              memGnt;
  logic              memValid;
  logic [DATA_W-1:0] memRdata;
  logic [ADDR_W-1:0] ramAddr;
  logic              ramWren;
  logic [DATA_W-1:0] ramWdata;
  logic [DATA_W-1:0] ramRdata;

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .fetchReq   (fetchReq),
    .fetchAddr  (fetchAddr),
    .fetchGnt   (fetchGnt),
    .fetchValid (fetchValid),
    .fetchData  (fetchData),
    .memReq     (memReq),
    .memWren    (memWren),
    .memAddr    (memAddr),
    .memWdata   (memWdata),
    .memGnt     (memGnt),
    .memValid   (memValid),
    .memRdata   (memRdata),
    .ramAddr    (ramAddr),
    .ramWren    (ramWren),
    .ramWdata   (ramWdata),
    .ramRdata   (ramRdata)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Environment RAM driven only by the DUT's port; the reference keeps its own copy.
  logic [DATA_W-1:0] ram_env [MEM_WORDS];
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];

  always @(posedge CLOCK_50) begin
    ramRdata <= ram_env[ramAddr];
    if (ramWren) ram_env[ramAddr] <= ramWdata;
  end

  function automatic logic [DATA_W-1:0] seed_word(input int a);
    return (DATA_W'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: results owed next cycle and how long fetch has been kept waiting.
  bit                pend_f, pend_m;
  logic [DATA_W-1:0] pend_f_data, pend_m_data;
  int                wait_cnt;
  bit                last_fg, last_mg;
  int                mem_gnt_count;

  task automatic step(input logic fr, input logic [ADDR_W-1:0] fa,
                      input logic mr, input logic mw, input logic [ADDR_W-1:0] ma,
                      input logic [DATA_W-1:0] wd, input logic rn);
    bit                force_e, mg, fg;
    logic [ADDR_W-1:0] exp_addr;
    fetchReq = fr; fetchAddr = fa;
    memReq = mr; memWren = mw; memAddr = ma; memWdata = wd;
    RESET_N = rn;
    if (!rn) begin
      pend_f = 0; pend_m = 0; wait_cnt = 0;
    end
    @(negedge CLOCK_50);
    force_e  = GUARD_EN && fr && (wait_cnt >= STARVE_LIMIT);
    mg       = mr && !force_e;
    fg       = fr && !mg;
    exp_addr = mg ? ma : (fg ? fa : '0);
    check("memGnt",     32'(memGnt),     32'(mg));
    check("fetchGnt",   32'(fetchGnt),   32'(fg));
    check("ramAddr",    32'(ramAddr),    32'(exp_addr));
    check("ramWren",    32'(ramWren),    32'(mg && mw && rn));
    if (mg) check("ramWdata", ramWdata, wd);
    check("fetchValid", 32'(fetchValid), 32'(pend_f));
    check("fetchData",  fetchData,       pend_f ? pend_f_data : '0);
    check("memValid",   32'(memValid),   32'(pend_m));
    check("memRdata",   memRdata,        pend_m ? pend_m_data : '0);
    @(posedge CLOCK_50);
    if (rn) begin
      pend_f      = fg;
      pend_f_data = ref_mem[fa];
      pend_m      = mg && !mw;
      pend_m_data = ref_mem[ma];
      if (mg && mw) ref_mem[ma] = wd;
      if (fg || !fr)     wait_cnt = 0;
      else if (mg)       wait_cnt = (wait_cnt < STARVE_LIMIT) ? wait_cnt + 1 : STARVE_LIMIT;
    end else begin
      pend_f = 0; pend_m = 0; wait_cnt = 0;
    end
    last_fg = fg;
    last_mg = mg;
    if (mg) mem_gnt_count++;
    #1;
  endtask

  logic              r_fr, r_mr, r_mw;
  logic [ADDR_W-1:0] r_fa, r_ma;
  logic [DATA_W-1:0] r_wd;
  logic              r_rn;

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      ram_env[i] = seed_word(i);
      ref_mem[i] = seed_word(i);
    end
    RESET_N = 1'b0;
    fetchReq = 0; fetchAddr = '0; memReq = 0; memWren = 0; memAddr = '0; memWdata = '0;
    pend_f = 0; pend_m = 0; wait_cnt = 0; mem_gnt_count = 0;
    @(posedge CLOCK_50); #1;

    // Reset state and idle
    step(0, '0, 0, 0, '0, '0, 0);
    step(0, '0, 0, 0, '0, '0, 0);
    step(0, '0, 0, 0, '0, '0, 1);

    // Lone fetch read
    step(1, 16'h0010, 0, 0, '0, '0, 1);
    check("lone_fetch_data", fetchData, seed_word(16'h0010));
    check("lone_fetch_memValid", 32'(memValid), 32'd0);
    step(0, '0, 0, 0, '0, '0, 1);

    // Both request: memory wins, then fetch
    step(1, 16'h0020, 1, 0, 16'h0100, '0, 1);
    check("both_mem_data", memRdata, seed_word(16'h0100));
    step(1, 16'h0020, 0, 0, '0, '0, 1);
    check("both_fetch_data", fetchData, seed_word(16'h0020));
    step(0, '0, 0, 0, '0, '0, 1);

    // Write then read-back by fetch
    step(0, '0, 1, 1, 16'h0200, 32'hDEAD_BEEF, 1);
    check("write_no_memValid", 32'(memValid), 32'd0);
    step(1, 16'h0200, 0, 0, '0, '0, 1);
    check("wr_rd_data", fetchData, 32'hDEAD_BEEF);
    step(0, '0, 0, 0, '0, '0, 1);

    // Both held high for nine cycles
    mem_gnt_count = 0;
    for (int i = 0; i < 9; i++) step(1, 16'h0030, 1, 0, 16'h0040, '0, 1);
    check("held_mem_grants", 32'(mem_gnt_count), GUARD_EN ? 32'd8 : 32'd9);
    step(0, '0, 0, 0, '0, '0, 1);

    // Reset right after a read grant
    step(1, 16'h0050, 0, 0, '0, '0, 1);
    step(0, '0, 1, 1, 16'h0060, 32'h1234_5678, 0);
    step(0, '0, 0, 0, '0, '0, 1);

    // Withdrawn fetch request
    step(1, 16'h0070, 1, 0, 16'h0080, '0, 1);
    step(0, '0, 0, 0, '0, '0, 1);
    step(0, '0, 0, 0, '0, '0, 1);

    // Randomized traffic; requests hold operands until granted or withdrawn
    r_fr = 0; r_mr = 0; r_mw = 0; r_fa = '0; r_ma = '0; r_wd = '0;
    last_fg = 0; last_mg = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!r_fr || last_fg || $urandom_range(0, 19) == 0) begin
        r_fr = ($urandom_range(0, 3) != 0);
        r_fa = ADDR_W'($urandom_range(0, 31));
      end
      if (!r_mr || last_mg || $urandom_range(0, 19) == 0) begin
        r_mr = ($urandom_range(0, 2) != 0);
        r_mw = ($urandom_range(0, 2) == 0);
        r_ma = ADDR_W'($urandom_range(0, 31));
        r_wd = DATA_W'($urandom);
      end
      r_rn = ($urandom_range(0, 99) != 0);
      step(r_fr, r_fa, r_mr, r_mw, r_ma, r_wd, r_rn);
      if (!r_rn) begin
        last_fg = 0; last_mg = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
